uart_rx_fifo_apb: RTL and testbench

Parametrised APB-attached UART receiver: configurable data width, optional parity, mid-bit sampling with glitch rejection, and a receive FIFO with error and overrun reporting. Sits on the APB peripheral bus beside the GPIO and UART transmit blocks, and replaces the single-byte, no-error-check receiver. Software drains received characters through a data register. It may poll status or use a level interrupt.

---
 rtl/uart_rx_fifo_apb.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo_apb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_apb.sv
// uart_rx_fifo_apb
//   APB-attached UART receiver with a small receive FIFO.
//   - Serial input is double-flopped, then a falling edge starts a frame.
//   - Each bit is sampled once, at its middle. A start bit that is high at
//     its mid sample is treated as a glitch and dropped silently.
//   - Good frames are pushed into a circular FIFO. Bad frames set sticky
//     error flags instead.
//
// Ports
//   PCLK, PRESET           clock, async active-high reset
//   PSEL/PENABLE/PWRITE    APB control (zero wait states)
//   PADDR, PWDATA          APB address / write data
//   PRDATA, PREADY, PSLVERR APB response (driven only in the access phase)
//   rx_serial              asynchronous serial line, idles high
//   rx_irq                 level interrupt
//
// Registers
//   0x00 RXDATA  RO  FIFO head, zero-extended; a read pops the FIFO
//   0x04 STATUS      [0] not_empty [1] full (RO);
//                    [2] overrun [3] frame_err [4] parity_err (W1C)
//   0x08 CTRL    RW  [0] rx_en [1] irq_en
module uart_rx_fifo_apb #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       rx_serial,
    output logic       rx_irq
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    // START samples one cycle early relative to the nominal half-bit wait,
    // because the cycle of the edge itself is spent in IDLE.
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    localparam logic [7:0] A_DATA = 8'h00;
    localparam logic [7:0] A_STAT = 8'h04;
    localparam logic [7:0] A_CTRL = 8'h08;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state, state_n;
    logic                sync1, sync2, sync_prev, fall;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                par_bad, par_exp, tick;
    logic                push_req, set_frm, set_par, set_ovr, push, pop;
    logic                rx_en, irq_en;
    logic [2:0]          sticky;   // {parity_err, frame_err, overrun}
    logic [2:0]          clr;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CNTW-1:0]      count;
    logic                 empty, full;

    logic                 access, wr, err;
    logic [7:0]           rdata;
    logic                 unused_ok;

    // ---------------- synchroniser and edge detect ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= rx_serial;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign fall    = sync_prev & ~sync2;
    assign par_exp = (PARITY_ODD != 0) ? ~^shreg : ^shreg;

    // ---------------- receive FSM ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        tick     = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
        push_req = 1'b0;
        set_frm  = 1'b0;
        set_par  = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:   if (fall) state_n = START;
                START:  if (tick) state_n = sync2 ? IDLE : DATA;
                DATA:   if (tick && bit_cnt == DATA_LAST)
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY: if (tick) state_n = STOP;
                STOP: begin
                    // Leave at the mid stop sample so a following start
                    // edge is seen even when frames are back to back.
                    if (tick) begin
                        state_n = IDLE;
                        if (!sync2)       set_frm  = 1'b1;
                        else if (par_bad) set_par  = 1'b1;
                        else              push_req = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // bit timer, bit counter, shift register, parity result
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            if (state == IDLE || tick) cnt <= '0;
            else                       cnt <= cnt + 1'b1;

            if (state != DATA) bit_cnt <= '0;
            else if (tick)     bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && tick) shreg <= {sync2, shreg[DATA_BITS-1:1]};

            if (state == START)              par_bad <= 1'b0;
            else if (state == PARITY && tick) par_bad <= (sync2 != par_exp);
        end
    end

    // ---------------- APB decode ----------------
    assign access = PSEL & PENABLE;
    assign wr     = access & PWRITE;
    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign pop    = access & ~PWRITE & (PADDR == A_DATA) & ~empty;
    assign clr    = (wr && PADDR == A_STAT) ? PWDATA[4:2] : 3'b000;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = push_req & (~full | pop);
    assign set_ovr = push_req & full & ~pop;

    always_comb begin
        rdata = 8'h00;
        err   = 1'b0;
        case (PADDR)
            A_DATA: begin
                if (PWRITE || empty) err = 1'b1;
                else                 rdata[DATA_BITS-1:0] = mem[rd_ptr];
            end
            A_STAT: rdata = {3'b000, sticky, full, ~empty};
            A_CTRL: rdata = {6'b0, irq_en, rx_en};
            default: err = 1'b1;
        endcase
    end

    assign PREADY  = access;
    assign PRDATA  = access ? rdata : 8'h00;
    assign PSLVERR = access & err;
    assign rx_irq  = irq_en & (~empty | (|sticky));

    // ---------------- control and sticky flags ----------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_en  <= 1'b0;
            irq_en <= 1'b0;
            sticky <= 3'b000;
        end else begin
            if (wr && PADDR == A_CTRL) {irq_en, rx_en} <= PWDATA[1:0];
            // set after clear so a coincident new event wins
            sticky <= (sticky & ~clr) | {set_par, set_frm, set_ovr};
        end
    end

    // ---------------- receive FIFO ----------------
    always_ff @(posedge PCLK) begin
        if (push) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign unused_ok = ^PWDATA[7:5];

endmodule

// File: tb/tb_uart_rx_fifo_apb.sv
// Directed bench for uart_rx_fifo_apb. Two instances share the clock,
// reset and APB bus; each has its own serial line and outputs:
//   dut0: 8 data bits, no parity;  dut1: 8 data bits, even parity.
module tb_uart_rx_fifo_apb;

    localparam int CPB = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic            PSEL, PENABLE, PWRITE;
    logic [7:0]      PADDR, PWDATA;
    logic [1:0][7:0] prdata;
    logic [1:0]      pready, pslverr, irq;
    logic [1:0]      rx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 PCLK = ~PCLK;

    uart_rx_fifo_apb #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                       .PARITY_ODD(0), .FIFO_DEPTH(4)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .rx_serial(rx[0]), .rx_irq(irq[0]));

    uart_rx_fifo_apb #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                       .PARITY_ODD(0), .FIFO_DEPTH(4)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .rx_serial(rx[1]), .rx_irq(irq[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_rd(input int sel, input logic [7:0] a,
                          output logic [7:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        chk("pready_setup", {31'b0, pready[sel]}, 0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = prdata[sel];
        e = pslverr[sel];
        chk("pready_access", {31'b0, pready[sel]}, 1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        e = pslverr[0];
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_chk(input int sel, input logic [7:0] a, input logic [7:0] exp_d,
                          input logic exp_e, input string tag);
        logic [7:0] d;
        logic       e;
        apb_rd(sel, a, d, e);
        chk({tag, "_data"}, {24'b0, d}, {24'b0, exp_d});
        chk({tag, "_slverr"}, {31'b0, e}, {31'b0, exp_e});
    endtask

    task automatic wr_q(input logic [7:0] a, input logic [7:0] d);
        logic e;
        apb_wr(a, d, e);
    endtask

    // Start bit, 8 data bits LSB first, optional parity, stop bit.
    // The line is left at the stop-bit value.
    task automatic send_frame(input int sel, input logic [7:0] data, input logic par_on,
                              input logic par_bit, input logic stop_bit);
        @(posedge PCLK); #1 rx[sel] = 1'b0;
        repeat (CPB) @(posedge PCLK);
        for (int i = 0; i < 8; i++) begin
            #1 rx[sel] = data[i];
            repeat (CPB) @(posedge PCLK);
        end
        if (par_on) begin
            #1 rx[sel] = par_bit;
            repeat (CPB) @(posedge PCLK);
        end
        #1 rx[sel] = stop_bit;
        repeat (CPB) @(posedge PCLK);
    endtask

    initial begin
        logic e;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 8'h00; rx = 2'b11;

        // ---- reset state ----
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_prdata", {24'b0, prdata[0]}, 0);
        chk("rst_pready", {31'b0, pready[0]}, 0);
        chk("rst_pslverr", {31'b0, pslverr[0]}, 0);
        chk("rst_irq", {30'b0, irq}, 0);
        @(posedge PCLK); #1 PRESET = 1'b0;
        rd_chk(0, 8'h08, 8'h00, 1'b0, "rst_ctrl");
        rd_chk(0, 8'h04, 8'h00, 1'b0, "rst_status");

        // ---- single frame 0xA5, push timing via rx_irq ----
        wr_q(8'h08, 8'h03);
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge PCLK);               // same edge the frame starts on
                repeat (153) @(posedge PCLK);  // cycle t0+151: stop sample
                @(negedge PCLK);
                chk("irq_before_push", {31'b0, irq[0]}, 0);
                @(negedge PCLK);               // cycle t0+152
                chk("irq_at_push", {31'b0, irq[0]}, 1);
            end
        join
        rd_chk(0, 8'h04, 8'h01, 1'b0, "a5_status");
        rd_chk(0, 8'h00, 8'hA5, 1'b0, "a5_rxdata");
        rd_chk(0, 8'h00, 8'h00, 1'b1, "empty_rxdata");
        rd_chk(0, 8'h04, 8'h00, 1'b0, "a5_status_after");

        // ---- bus errors ----
        rd_chk(0, 8'h0C, 8'h00, 1'b1, "unmapped_rd");
        apb_wr(8'h00, 8'h55, e);
        chk("wr_rxdata_slverr", {31'b0, e}, 1);
        apb_wr(8'h10, 8'h55, e);
        chk("wr_unmapped_slverr", {31'b0, e}, 1);
        rd_chk(0, 8'h08, 8'h03, 1'b0, "ctrl_unchanged");

        // ---- frame error, then line held low ----
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (300) @(posedge PCLK);
        #1 rx[0] = 1'b1;
        repeat (10) @(posedge PCLK);
        rd_chk(0, 8'h04, 8'h08, 1'b0, "frame_err");
        wr_q(8'h04, 8'h08);
        rd_chk(0, 8'h04, 8'h00, 1'b0, "frame_err_clr");

        // ---- overrun: 5 frames into a 4-deep FIFO ----
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        rd_chk(0, 8'h04, 8'h07, 1'b0, "ovr_status");
        for (int i = 1; i <= 4; i++) rd_chk(0, 8'h00, 8'(i), 1'b0, "ovr_rd");
        rd_chk(0, 8'h00, 8'h00, 1'b1, "ovr_rd_empty");
        wr_q(8'h04, 8'h04);
        rd_chk(0, 8'h04, 8'h00, 1'b0, "ovr_clr");

        // ---- pop landing on the push cycle of a full FIFO ----
        for (int i = 0; i < 4; i++) send_frame(0, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
        rd_chk(0, 8'h04, 8'h03, 1'b0, "full_status");
        fork
            send_frame(0, 8'h15, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge PCLK);
                repeat (151) @(posedge PCLK);  // access phase = stop-sample cycle
                rd_chk(0, 8'h00, 8'h11, 1'b0, "pop_on_push");
            end
        join
        rd_chk(0, 8'h04, 8'h03, 1'b0, "pop_push_status");
        for (int i = 0; i < 4; i++) rd_chk(0, 8'h00, 8'h12 + 8'(i), 1'b0, "pp_rd");
        rd_chk(0, 8'h00, 8'h00, 1'b1, "pp_rd_empty");

        // ---- 3-cycle glitch ----
        @(posedge PCLK); #1 rx[0] = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 rx[0] = 1'b1;
        repeat (60) @(posedge PCLK);
        rd_chk(0, 8'h04, 8'h00, 1'b0, "glitch");

        // ---- rx_en cleared mid-frame ----
        fork
            send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
            begin
                repeat (60) @(posedge PCLK);
                wr_q(8'h08, 8'h02);
            end
        join
        repeat (10) @(posedge PCLK);
        rd_chk(0, 8'h04, 8'h00, 1'b0, "abort_status");
        rd_chk(0, 8'h00, 8'h00, 1'b1, "abort_rxdata");
        wr_q(8'h08, 8'h03);

        // ---- parity (dut1, even) ----
        send_frame(1, 8'h0F, 1'b1, 1'b0, 1'b1);
        rd_chk(1, 8'h04, 8'h01, 1'b0, "par_ok_status");
        send_frame(1, 8'h0F, 1'b1, 1'b1, 1'b1);
        rd_chk(1, 8'h04, 8'h11, 1'b0, "par_err_status");
        rd_chk(1, 8'h00, 8'h0F, 1'b0, "par_rxdata");
        rd_chk(1, 8'h00, 8'h00, 1'b1, "par_rxdata_empty");
        wr_q(8'h04, 8'h10);
        rd_chk(1, 8'h04, 8'h00, 1'b0, "par_err_clr");

        // ---- reset mid-frame ----
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b1);
        @(negedge PCLK);
        chk("irq_before_reset", {31'b0, irq[0]}, 1);
        fork
            send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
            begin
                repeat (80) @(posedge PCLK);
                #3 PRESET = 1'b1;
                #1;
                chk("midrst_irq", {31'b0, irq[0]}, 0);
                chk("midrst_prdata", {24'b0, prdata[0]}, 0);
                chk("midrst_pslverr", {31'b0, pslverr[0]}, 0);
                chk("midrst_pready", {31'b0, pready[0]}, 0);
                @(posedge PCLK); #1 PRESET = 1'b0;
            end
        join
        repeat (20) @(posedge PCLK);
        rd_chk(0, 8'h08, 8'h00, 1'b0, "midrst_ctrl");
        rd_chk(0, 8'h04, 8'h00, 1'b0, "midrst_status");
        rd_chk(0, 8'h00, 8'h00, 1'b1, "midrst_rxdata");
        wr_q(8'h08, 8'h01);
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        rd_chk(0, 8'h00, 8'h42, 1'b0, "post_rst_rx");
        @(negedge PCLK);
        chk("irq_disabled", {31'b0, irq[0]}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
